// File: rtl/btn_sel_toggle_pkg.sv
// Shared definitions for the button-driven select toggle: debounce FSM states
// and default debounce timing (10 ms at 50 MHz).
package btn_sel_toggle_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PWAIT   = 2'd1,
        ST_PRESSED = 2'd2,
        ST_RWAIT   = 2'd3
    } state_t;

    localparam int unsigned DB_CYCLES_DEF = 500000;
    localparam int unsigned CNT_W_DEF     = 19;

endpackage

// File: rtl/btn_sel_toggle_sync_2ff.sv
// Two-flop synchroniser with synchronous reset for asynchronous single-bit inputs.
// Planned for reuse on the other button inputs.
module sync_2ff (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/btn_sel_toggle.sv
// Debounces a raw push-button and toggles a registered mux select on each clean
// press; a synchronous load can force the select and takes priority over a toggle.
module btn_sel_toggle
    import btn_sel_toggle_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter logic        SEL_INIT  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    input  logic sel_load,
    input  logic sel_val,
    output logic sel,
    output logic sel_changed,
    output logic btn_level
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             bs;
    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             level_q;
    logic             sel_q;
    logic             sel_d;
    logic             changed_q;
    logic             changed_d;
    logic             toggle_req;

    sync_2ff u_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (btn_in),
        .q_o   (bs)
    );

    // The press is accepted on the same edge the FSM enters PRESSED.
    always_comb begin
        toggle_req = (state_q == ST_PWAIT) && bs && (cnt_q == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bs) begin
                        state_q <= ST_PWAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_PWAIT: begin
                    if (!bs) begin
                        state_q <= ST_IDLE;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_PRESSED;
                        level_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!bs) begin
                        state_q <= ST_RWAIT;
                        cnt_q   <= '0;
                    end
                end
                ST_RWAIT: begin
                    if (bs) begin
                        state_q <= ST_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ST_IDLE;
                        level_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        sel_d = sel_q;
        if (sel_load) begin
            sel_d = sel_val;
        end else if (toggle_req) begin
            sel_d = ~sel_q;
        end
        changed_d = (sel_d != sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q     <= SEL_INIT;
            changed_q <= 1'b0;
        end else begin
            sel_q     <= sel_d;
            changed_q <= changed_d;
        end
    end

    assign sel         = sel_q;
    assign sel_changed = changed_q;
    assign btn_level   = level_q;

endmodule

// File: tb/tb_btn_sel_toggle.sv
// Self-checking bench for btn_sel_toggle: directed scenarios plus random button
// activity, compared each cycle against a run-length debounce reference model.
module tb_btn_sel_toggle;

    localparam int unsigned DB = 4;
    localparam int unsigned CW = 3;
    localparam logic        SI = 1'b0;

    logic clk = 1'b0;
    logic rst;
    logic btn_in;
    logic sel_load;
    logic sel_val;
    logic sel;
    logic sel_changed;
    logic btn_level;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    btn_sel_toggle #(
        .DB_CYCLES (DB),
        .CNT_W     (CW),
        .SEL_INIT  (SI)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_in      (btn_in),
        .sel_load    (sel_load),
        .sel_val     (sel_val),
        .sel         (sel),
        .sel_changed (sel_changed),
        .btn_level   (btn_level)
    );

    // Reference: the button level the FSM sees is btn_in from two edges back;
    // the debounced level flips once DB+1 consecutive samples disagree with it.
    logic [1:0] m_hist;
    int         m_run;
    logic       m_level;
    logic       m_sel;
    logic       m_chg;

    always @(posedge clk) begin
        logic seen;
        logic tog;
        logic nsel;
        if (rst) begin
            m_hist  = 2'b00;
            m_run   = 0;
            m_level = 1'b0;
            m_sel   = SI;
            m_chg   = 1'b0;
        end else begin
            seen   = m_hist[1];
            m_hist = {m_hist[0], btn_in};
            tog    = 1'b0;
            if (seen != m_level) begin
                m_run++;
                if (m_run == int'(DB) + 1) begin
                    m_level = seen;
                    m_run   = 0;
                    tog     = seen;
                end
            end else begin
                m_run = 0;
            end
            nsel  = sel_load ? sel_val : (tog ? ~m_sel : m_sel);
            m_chg = (nsel != m_sel);
            m_sel = nsel;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_eq("sel", {31'd0, sel}, {31'd0, m_sel});
        check_eq("sel_changed", {31'd0, sel_changed}, {31'd0, m_chg});
        check_eq("btn_level", {31'd0, btn_level}, {31'd0, m_level});
    endtask

    // Runs n cycles; reports pulse count, first pulse cycle (1-based) and level changes.
    task automatic run_cycles(input int n, output int pulses, output int first, output int lvl_chg);
        logic prev;
        pulses  = 0;
        first   = 0;
        lvl_chg = 0;
        prev    = btn_level;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (sel_changed) begin
                pulses++;
                if (first == 0) first = i;
            end
            if (btn_level != prev) lvl_chg++;
            prev = btn_level;
        end
    endtask

    initial begin
        int pulses;
        int first;
        int lvl;
        int remain;

        rst      = 1'b1;
        btn_in   = 1'b1;
        sel_load = 1'b0;
        sel_val  = 1'b0;
        @(negedge clk);

        // Reset held 3 cycles with the button pressed
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("rst_sel", {31'd0, sel}, 32'd0);
            check_eq("rst_pulse", {31'd0, sel_changed}, 32'd0);
            check_eq("rst_level", {31'd0, btn_level}, 32'd0);
        end
        rst = 1'b0;

        // Held button after reset: single toggle at E+DB+2 (cycle 7 counting E as 1)
        run_cycles(20, pulses, first, lvl);
        check_eq("press_pulses", pulses, 32'd1);
        check_eq("press_latency", first, DB + 3);
        check_eq("press_sel", {31'd0, sel}, 32'd1);
        check_eq("press_level", {31'd0, btn_level}, 32'd1);

        // Bouncy release 0,1,0,0,0,0,0 then settle
        btn_in = 1'b0; tick();
        btn_in = 1'b1; tick();
        btn_in = 1'b0;
        run_cycles(14, pulses, first, lvl);
        check_eq("release_level_fall", lvl, 32'd1);
        check_eq("release_pulses", pulses, 32'd0);
        check_eq("release_level", {31'd0, btn_level}, 32'd0);

        // Clean press toggles back to 0
        btn_in = 1'b1;
        run_cycles(12, pulses, first, lvl);
        check_eq("press2_pulses", pulses, 32'd1);
        check_eq("press2_sel", {31'd0, sel}, 32'd0);
        btn_in = 1'b0;
        run_cycles(12, pulses, first, lvl);

        // Glitch of 3 cycles is rejected
        btn_in = 1'b1;
        run_cycles(3, pulses, first, lvl);
        btn_in = 1'b0;
        run_cycles(10, pulses, first, lvl);
        check_eq("glitch_sel", {31'd0, sel}, 32'd0);
        check_eq("glitch_level", {31'd0, btn_level}, 32'd0);

        // Load of 0 on the toggle edge beats the toggle: no change, no pulse
        btn_in = 1'b1;
        run_cycles(DB + 2, pulses, first, lvl);
        check_eq("load0_pre_pulses", pulses, 32'd0);
        sel_load = 1'b1; sel_val = 1'b0;
        tick();
        sel_load = 1'b0;
        check_eq("load0_sel", {31'd0, sel}, 32'd0);
        check_eq("load0_pulse", {31'd0, sel_changed}, 32'd0);
        check_eq("load0_level", {31'd0, btn_level}, 32'd1);
        btn_in = 1'b0;
        run_cycles(12, pulses, first, lvl);

        // Load of 1 on the toggle edge: one pulse, sel=1
        btn_in = 1'b1;
        run_cycles(DB + 2, pulses, first, lvl);
        sel_load = 1'b1; sel_val = 1'b1;
        tick();
        sel_load = 1'b0;
        check_eq("load1_sel", {31'd0, sel}, 32'd1);
        check_eq("load1_pulse", {31'd0, sel_changed}, 32'd1);
        run_cycles(6, pulses, first, lvl);
        check_eq("load1_no_extra", pulses, 32'd0);
        btn_in = 1'b0;
        run_cycles(12, pulses, first, lvl);

        // Reset mid-PWAIT with the button held: re-debounced from SEL_INIT
        btn_in = 1'b1;
        run_cycles(5, pulses, first, lvl);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_sel", {31'd0, sel}, 32'd0);
        run_cycles(12, pulses, first, lvl);
        check_eq("midrst_pulses", pulses, 32'd1);
        check_eq("midrst_latency", first, DB + 3);
        check_eq("midrst_sel_after", {31'd0, sel}, 32'd1);

        // Random button activity with occasional loads and resets
        remain = 0;
        for (int i = 0; i < 600; i++) begin
            if (remain == 0) begin
                btn_in = 1'($urandom);
                remain = int'($urandom_range(1, 9));
            end
            remain--;
            rst      = ($urandom_range(0, 99) == 0);
            sel_load = ($urandom_range(0, 11) == 0);
            sel_val  = 1'($urandom);
            tick();
        end
        rst      = 1'b0;
        sel_load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
